// File: rtl/data_mem_lsu_if.sv
// Request/response bus of the word-wide data memory load/store unit.
// The master issues loads and stores. The slave returns one response per accepted request.
interface data_mem_lsu_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Big-endian MIPS data memory: four byte banks behind one request port.
// It supports byte, half and word loads and stores, and an optional INIT_BYTE sweep after reset.
module data_mem_lane #(
  parameter int WIDX_W = 7
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [WIDX_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              re_i,
  input  logic [WIDX_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);
  logic [7:0] mem_q [2**WIDX_W];
  logic [7:0] rdata_q;

  // The contents have no reset, so they survive a reset when no clear sweep runs.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module data_mem_lsu #(
  parameter int         ADDR_W         = 9,
  parameter logic [7:0] INIT_BYTE      = 8'hFF,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_lsu_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int WIDX_W    = ADDR_W - 2;
  localparam int DEPTH     = 2**WIDX_W;

  typedef enum logic {S_CLEAR, S_RUN} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_e            state_q, state_d;
  logic [WIDX_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RST_STATE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == WIDX_W'(DEPTH-1)) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  logic              acc, err_c, st_ok;
  logic [1:0]        off;
  logic [WIDX_W-1:0] widx;

  assign bus.req_ready = (state_q == S_RUN);
  assign acc   = bus.req_valid && bus.req_ready;
  assign off   = bus.req_addr[1:0];
  assign widx  = bus.req_addr[ADDR_W-1:2];
  assign err_c = (bus.req_size == 2'b11) ||
                 (bus.req_size == 2'b01 && off[0]) ||
                 (bus.req_size == 2'b10 && off != 2'b00);
  assign st_ok = acc && bus.req_we && !err_c;

  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_wd, lane_rd;

  // Lane 0 holds the most significant byte of each word.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LI = 2'(i);
    logic       sel;
    logic [7:0] st_byte;

    always_comb begin
      sel     = 1'b1;
      st_byte = bus.req_wdata[31-8*i -: 8];
      case (bus.req_size)
        2'b00: begin
          sel     = (off == LI);
          st_byte = bus.req_wdata[7:0];
        end
        2'b01: begin
          sel     = (off[1] == LI[1]);
          st_byte = LI[0] ? bus.req_wdata[7:0] : bus.req_wdata[15:8];
        end
        default: ;
      endcase
    end

    assign lane_we[i] = clr_we || (st_ok && sel);
    assign lane_wd[i] = clr_we ? INIT_BYTE : st_byte;

    data_mem_lane #(.WIDX_W(WIDX_W)) u_lane (
      .clk     (clk),
      .we_i    (lane_we[i]),
      .waddr_i (clr_we ? clr_ptr_q : widx),
      .wdata_i (lane_wd[i]),
      .re_i    (acc),
      .raddr_i (widx),
      .rdata_o (lane_rd[i])
    );
  end

  logic       rsp_valid_q, rsp_err_q, rsp_ld_q, sgn_q;
  logic [1:0] size_q, off_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ld_q    <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
    end else begin
      rsp_valid_q <= acc;
      rsp_err_q   <= acc && err_c;
      rsp_ld_q    <= acc && !bus.req_we && !err_c;
      if (acc) begin
        sgn_q  <= bus.req_signed;
        size_q <= bus.req_size;
        off_q  <= off;
      end
    end
  end

  logic [31:0] word_rd, rdata;
  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    word_rd = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
    byte_v  = lane_rd[off_q];
    half_v  = off_q[1] ? word_rd[15:0] : word_rd[31:16];
    rdata   = '0;
    if (rsp_ld_q) begin
      case (size_q)
        2'b00:   rdata = {{24{sgn_q & byte_v[7]}}, byte_v};
        2'b01:   rdata = {{16{sgn_q & half_v[15]}}, half_v};
        default: rdata = word_rd;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rdata;
  assign bus.init_done = (state_q == S_RUN);
endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu. It uses a vector table, hand-written reset and sweep sequences,
// and random traffic checked against a byte-array memory model.
module tb_data_mem_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem_m [512];

  always #5 clk = ~clk;

  data_mem_lsu_if #(.ADDR_W(9)) bus ();

  data_mem_lsu #(.ADDR_W(9), .INIT_BYTE(8'hFF), .CLEAR_ON_RESET(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    bit          sg;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] ed;
    bit          ee;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Memory model: a flat byte array indexed by byte address, big-endian.
  function automatic void model(input bit we, input logic [1:0] sz, input bit sg, input int a,
                                input logic [31:0] wd, output logic [31:0] d, output bit e);
    int n = 1 << sz;
    e = (sz == 2'b11) || (a % n != 0);
    d = 32'h0;
    if (e) return;
    if (we) begin
      for (int k = 0; k < n; k++) mem_m[a+k] = 8'(wd >> (8*(n-1-k)));
    end else begin
      for (int k = 0; k < n; k++) d = (d << 8) | 32'(mem_m[a+k]);
      if (sg && n < 4 && d[8*n-1]) d = d | (32'hFFFF_FFFF << (8*n));
    end
  endfunction

  task automatic req(input bit we, input logic [1:0] sz, input bit sg, input logic [8:0] a,
                     input logic [31:0] wd, input logic [31:0] ed, input bit ee, input string nm);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check({nm, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({nm, "_rdata"}, bus.rsp_rdata, ed);
    check({nm, "_err"}, 32'(bus.rsp_err), 32'(ee));
  endtask

  task automatic sweep(input string nm);
    int  cyc = 0;
    bit  quiet = 1'b1;
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.rsp_valid) quiet = 1'b0;
      if (bus.init_done) break;
    end
    bus.req_valid = 1'b0;
    check({nm, "_len"}, 32'(cyc), 32'd128);
    check({nm, "_quiet"}, 32'(quiet), 32'd1);
    for (int i = 0; i < 512; i++) mem_m[i] = 8'hFF;
  endtask

  initial begin
    vec_t        tv[$];
    logic [31:0] d;
    bit          e;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);

    // A request is held during the sweep and must be ignored.
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 9'h1FC; bus.req_wdata = 32'h0;
    sweep("sweep1");
    req(1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0, 32'hFFFF_FFFF, 1'b0, "clear_load");

    tv.push_back('{1, 2'd2, 0, 9'h010, 32'h1234_5678, 32'h0, 0});
    tv.push_back('{0, 2'd0, 0, 9'h010, 32'h0, 32'h12, 0});
    tv.push_back('{0, 2'd0, 0, 9'h011, 32'h0, 32'h34, 0});
    tv.push_back('{0, 2'd0, 0, 9'h012, 32'h0, 32'h56, 0});
    tv.push_back('{0, 2'd0, 0, 9'h013, 32'h0, 32'h78, 0});
    tv.push_back('{0, 2'd0, 1, 9'h011, 32'h0, 32'h34, 0});
    tv.push_back('{1, 2'd2, 0, 9'h020, 32'hA1B2_C3D4, 32'h0, 0});
    tv.push_back('{1, 2'd0, 0, 9'h021, 32'hFFFF_FF80, 32'h0, 0});
    tv.push_back('{0, 2'd0, 1, 9'h021, 32'h0, 32'hFFFF_FF80, 0});
    tv.push_back('{0, 2'd0, 0, 9'h021, 32'h0, 32'h80, 0});
    tv.push_back('{0, 2'd0, 0, 9'h020, 32'h0, 32'hA1, 0});
    tv.push_back('{0, 2'd0, 0, 9'h022, 32'h0, 32'hC3, 0});
    tv.push_back('{0, 2'd0, 0, 9'h023, 32'h0, 32'hD4, 0});
    tv.push_back('{1, 2'd1, 0, 9'h032, 32'h0000_BEEF, 32'h0, 0});
    tv.push_back('{0, 2'd1, 1, 9'h032, 32'h0, 32'hFFFF_BEEF, 0});
    tv.push_back('{0, 2'd1, 0, 9'h032, 32'h0, 32'h0000_BEEF, 0});
    tv.push_back('{0, 2'd2, 0, 9'h030, 32'h0, 32'hFFFF_BEEF, 0});
    tv.push_back('{0, 2'd1, 1, 9'h030, 32'h0, 32'hFFFF_FFFF, 0});
    tv.push_back('{1, 2'd2, 0, 9'h040, 32'hCAFE_F00D, 32'h0, 0});
    tv.push_back('{1, 2'd1, 0, 9'h041, 32'h0000_1111, 32'h0, 1});
    tv.push_back('{0, 2'd2, 0, 9'h042, 32'h0, 32'h0, 1});
    tv.push_back('{0, 2'd3, 0, 9'h040, 32'h0, 32'h0, 1});
    tv.push_back('{1, 2'd3, 0, 9'h040, 32'h2222_2222, 32'h0, 1});
    tv.push_back('{1, 2'd2, 0, 9'h042, 32'h3333_3333, 32'h0, 1});
    tv.push_back('{0, 2'd2, 0, 9'h040, 32'h0, 32'hCAFE_F00D, 0});

    for (int i = 0; i < tv.size(); i++) begin
      model(tv[i].we, tv[i].sz, tv[i].sg, int'(tv[i].a), tv[i].wd, d, e);
      req(tv[i].we, tv[i].sz, tv[i].sg, tv[i].a, tv[i].wd, tv[i].ed, tv[i].ee,
          $sformatf("vec%0d", i));
    end

    // Random traffic in a small window so read-after-write hits are frequent.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check($sformatf("rnd%0d_idle", i), 32'(bus.rsp_valid), 32'd0);
      end else begin
        bit          we = 1'($urandom_range(0, 1));
        bit          sg = 1'($urandom_range(0, 1));
        logic [1:0]  sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        int          a  = $urandom_range(9'h1C0, 9'h1FF);
        logic [31:0] wd = $urandom;
        if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
        model(we, sz, sg, a, wd, d, e);
        req(we, sz, sg, 9'(a), wd, d, e, $sformatf("rnd%0d", i));
      end
    end

    // A pending response is dropped by reset, and a sweep interrupted by reset restarts.
    req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 32'h1234_5678, 1'b0, "pre_rst");
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_discard", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_init_done", 32'(bus.init_done), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep("sweep2");
    req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 32'hFFFF_FFFF, 1'b0, "resweep_load");
    req(1'b1, 2'b10, 1'b0, 9'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, "raw_st");
    req(1'b0, 2'b10, 1'b0, 9'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, "raw_ld");
    req(1'b0, 2'b00, 1'b1, 9'h101, 32'h0, 32'hFFFF_FFAD, 1'b0, "raw_ldb");
    @(posedge clk); #1;
    check("final_idle", 32'(bus.rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
